// File: rtl/color_frame_ctrl_pkg.sv
// ============================================================================
// Module : color_frame_ctrl_pkg
// Brief  : Color codes and FSM state encodings for the VGA color path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package color_frame_ctrl_pkg;

    typedef logic [2:0] color_t;

    localparam color_t CLR_BLACK   = 3'd0;
    localparam color_t CLR_BLUE    = 3'd1;
    localparam color_t CLR_GREEN   = 3'd2;
    localparam color_t CLR_CYAN    = 3'd3;
    localparam color_t CLR_RED     = 3'd4;
    localparam color_t CLR_MAGENTA = 3'd5;
    localparam color_t CLR_YELLOW  = 3'd6;
    localparam color_t CLR_WHITE   = 3'd7;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME   = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/color_frame_ctrl_btn_priority_enc.sv
// ============================================================================
// Module : btn_priority_enc
// Brief  : Combinational 8->3 highest-set-bit encoder with any-valid flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_priority_enc
    import color_frame_ctrl_pkg::*;
(
    input  logic [7:0] i_btn,
    output color_t     o_code,
    output logic       o_valid
);

    always_comb begin
        o_code = CLR_BLACK;
        for (int i = 0; i < 8; i++) begin
            if (i_btn[i]) begin
                o_code = 3'(i);
            end
        end
    end

    assign o_valid = |i_btn;

endmodule

`default_nettype wire

// File: rtl/color_frame_ctrl.sv
// ============================================================================
// Module : color_frame_ctrl
// Brief  : Debounces/arbitrates color buttons, commits color at frame start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module color_frame_ctrl
    import color_frame_ctrl_pkg::*;
#(
    parameter int         DB_COUNT    = 250000,
    parameter logic [2:0] RESET_COLOR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] btn,
    output logic [2:0] color_rgb,
    output logic       color_update,
    output logic       pending
);

    localparam int                 c_CNT_W    = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DB_COUNT - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    color_t             r_cand;
    color_t             r_color;
    logic               r_update;
    logic               r_pending;
    color_t             w_enc_code;
    logic               w_enc_valid;

    btn_priority_enc u_enc (
        .i_btn   (btn),
        .o_code  (w_enc_code),
        .o_valid (w_enc_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cand    <= CLR_BLACK;
            r_color   <= RESET_COLOR;
            r_update  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_enc_valid) begin
                        r_cand  <= w_enc_code;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    // Only the latched candidate matters; later presses are ignored.
                    if (!btn[r_cand]) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_WAIT_FRAME;
                        r_pending <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        r_color   <= r_cand;
                        r_update  <= 1'b1;
                        r_pending <= 1'b0;
                        r_state   <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (btn == 8'h00) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign color_rgb    = r_color;
    assign color_update = r_update;
    assign pending      = r_pending;

endmodule

`default_nettype wire
